segment_cycle_profiler: RTL and testbench

Hardware cycle profiler that sits beside the single-cycle processor and replaces bench-side per-store cycle bookkeeping. It counts clock cycles per segment, where a segment ends on each `event` strobe (typically the core's `MemWrite`), and stores each segment's count in a `DEPTH`-entry array. It also keeps a saturating grand total. The array is read back through a registered port, so software or a bench can collect per-result and total cycle costs without probing internal memories.

---
 rtl/profiler_pkg.sv | 20 ++
 rtl/segment_cycle_profiler_sat_counter.sv | 32 +++
 rtl/segment_cycle_profiler.sv | 147 ++++++++++++++
 tb/tb_segment_cycle_profiler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/profiler_pkg.sv
// Shared types and helpers for the segment cycle profiler.
package profiler_pkg;

    // Profiler control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    // Values accepted by the WRAP parameter.
    localparam int STOP = 0;
    localparam int CIRC = 1;

    // Address width for a DEPTH-entry array; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/segment_cycle_profiler_sat_counter.sv
// Saturating incrementer: computes the next value of a counter from its
// current value. Kept combinational so one instance can serve whichever
// array entry is selected, and another can feed the total register.
module sat_counter #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    // Next value: clear wins, otherwise step by one and stick at MAX.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        q   = cur;
        sat = 1'b0;
        if (clr) begin
            q = '0;
        end else if (inc) begin
            if (cur != MAX) begin
                q = cur + 1'b1;
            end
            // Pulse whenever this increment leaves the counter at its ceiling.
            sat = (q == MAX);
        end
    end

endmodule

// File: rtl/segment_cycle_profiler.sv
// Per-segment cycle profiler: counts enabled cycles into the currently open
// segment entry, closes a segment on each strobe, keeps a saturating grand
// total, and exposes the entries through a registered read port.
// The segment-end strobe is named evt because "event" is a reserved word.
module segment_cycle_profiler
    import profiler_pkg::*;
#(
    parameter  int CNT_W = 16,
    parameter  int TOT_W = 32,
    parameter  int DEPTH = 20,
    parameter  int WRAP  = 0,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             evt,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic [IDX_W-1:0] seg_idx,
    output logic [TOT_W-1:0] total,
    output logic             sat,
    output logic             full,
    output logic             wrapped
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count [DEPTH];

    logic             wipe;
    logic             counting;
    logic             advance;
    logic             at_last;
    logic [IDX_W-1:0] enter_idx;
    logic [CNT_W-1:0] seg_next;
    logic             seg_sat;
    logic [TOT_W-1:0] tot_next;
    logic             tot_sat;

    // Cycle qualification: a cycle counts only when enabled and not yet full.
    always_comb begin
        wipe      = reset | clear;
        counting  = enable && (state != FULL);
        advance   = counting && evt;
        at_last   = (seg_idx == LAST);
        enter_idx = at_last ? '0 : seg_idx + 1'b1;
    end

    // Shared incrementer for whichever entry is currently open.
    sat_counter #(.W(CNT_W)) u_seg_inc (
        .cur (count[seg_idx]),
        .inc (counting),
        .clr (1'b0),
        .q   (seg_next),
        .sat (seg_sat)
    );

    // Incrementer for the grand total; soft clear and reset zero it.
    sat_counter #(.W(TOT_W)) u_tot_inc (
        .cur (total),
        .inc (counting),
        .clr (wipe),
        .q   (tot_next),
        .sat (tot_sat)
    );

    // Next-state decode; the state always mirrors this cycle's enable
    // until the last entry closes in stop mode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, RUN: begin
                if (advance && at_last && (WRAP == STOP)) begin
                    state_n = FULL;
                end else if (enable) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            FULL:    state_n = FULL;
            default: state_n = IDLE;
        endcase
    end

    // State register; reset and clear both return to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (wipe) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Segment index, sticky flags and total.
    always_ff @(posedge clk) begin
        if (wipe) begin
            seg_idx <= '0;
            sat     <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            if (advance) begin
                if (!at_last) begin
                    seg_idx <= enter_idx;
                end else if (WRAP == CIRC) begin
                    seg_idx <= '0;
                    wrapped <= 1'b1;
                end
            end
            if (seg_sat || tot_sat) begin
                sat <= 1'b1;
            end
        end
        total <= tot_next;
    end

    // Entry array and registered read port.
    always_ff @(posedge clk) begin
        if (wipe) begin
            // NOTE: the array is register-based and must read back as zero after clear, so every entry is reset.
            for (int i = 0; i < DEPTH; i++) begin
                count[i] <= '0;
            end
            rd_count <= '0;
        end else begin
            if (counting) begin
                count[seg_idx] <= seg_next;
            end
            // In circular mode the entry being entered starts from zero so it
            // only ever holds cycles from its newest segment.
            if (advance && (WRAP == CIRC) && (at_last || (int'(seg_idx) < DEPTH - 1))) begin
                count[enter_idx] <= '0;
            end
            // Read returns the pre-edge value; out-of-range addresses read zero.
            rd_count <= (int'(rd_idx) < DEPTH) ? count[rd_idx] : '0;
        end
    end

    // Only output decoded straight from the state register.
    assign full = (state == FULL);

endmodule

// File: tb/tb_segment_cycle_profiler.sv
// Directed bench for segment_cycle_profiler: three instances share stimulus
// (DEPTH=4 stop mode, DEPTH=4 circular mode, DEPTH=5 stop mode for the
// out-of-range read address), with read-port expectations queued at drive
// time and compared one cycle later.
module tb_segment_cycle_profiler;

    localparam int CNT_W = 4;
    localparam int TOT_W = 8;

    typedef struct {
        string tag;
        int    exp_stop;
        int    exp_circ;
        int    exp_odd;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset, enable, evt, clear;
    logic [1:0] rd_idx;
    logic [2:0] rd_idx5;

    logic [CNT_W-1:0] s_rd, c_rd, o_rd;
    logic [1:0]       s_seg, c_seg;
    logic [2:0]       o_seg;
    logic [TOT_W-1:0] s_tot, c_tot, o_tot;
    logic             s_sat, c_sat, o_sat;
    logic             s_full, c_full, o_full;
    logic             s_wrap, c_wrap, o_wrap;

    int checks = 0;
    int errors = 0;
    rd_exp_t rq[$];

    always #5 clk = ~clk;

    segment_cycle_profiler #(.CNT_W(CNT_W), .TOT_W(TOT_W), .DEPTH(4), .WRAP(0)) u_stop (
        .clk(clk), .reset(reset), .enable(enable), .evt(evt), .clear(clear),
        .rd_idx(rd_idx), .rd_count(s_rd), .seg_idx(s_seg), .total(s_tot),
        .sat(s_sat), .full(s_full), .wrapped(s_wrap)
    );

    segment_cycle_profiler #(.CNT_W(CNT_W), .TOT_W(TOT_W), .DEPTH(4), .WRAP(1)) u_circ (
        .clk(clk), .reset(reset), .enable(enable), .evt(evt), .clear(clear),
        .rd_idx(rd_idx), .rd_count(c_rd), .seg_idx(c_seg), .total(c_tot),
        .sat(c_sat), .full(c_full), .wrapped(c_wrap)
    );

    segment_cycle_profiler #(.CNT_W(CNT_W), .TOT_W(TOT_W), .DEPTH(5), .WRAP(0)) u_odd (
        .clk(clk), .reset(reset), .enable(enable), .evt(evt), .clear(clear),
        .rd_idx(rd_idx5), .rd_count(o_rd), .seg_idx(o_seg), .total(o_tot),
        .sat(o_sat), .full(o_full), .wrapped(o_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge,
    // and retire any read expectation queued for this edge.
    task automatic step(input logic en, input logic ev, input logic clr = 1'b0, input logic rst = 1'b0);
        rd_exp_t e;
        enable = en;
        evt    = ev;
        clear  = clr;
        reset  = rst;
        @(posedge clk);
        @(negedge clk);
        if (rq.size() != 0) begin
            e = rq.pop_front();
            check({e.tag, "/stop"}, 32'(s_rd), e.exp_stop);
            check({e.tag, "/circ"}, 32'(c_rd), e.exp_circ);
            check({e.tag, "/odd"},  32'(o_rd), e.exp_odd);
        end
    endtask

    // Queue a read and idle one cycle so the registered data appears.
    task automatic rd(input int i, input int i5, input int es, input int ec, input int eo, input string tag);
        rd_idx  = 2'(i);
        rd_idx5 = 3'(i5);
        rq.push_back('{tag, es, ec, eo});
        step(1'b0, 1'b0);
    endtask

    task automatic chk_state(input string tag, input int tot_s, input int seg_s, input int full_s,
                             input int tot_c, input int seg_c, input int wrap_c);
        check({tag, "/stop_total"}, 32'(s_tot), tot_s);
        check({tag, "/stop_seg"},   32'(s_seg), seg_s);
        check({tag, "/stop_full"},  32'(s_full), full_s);
        check({tag, "/circ_total"}, 32'(c_tot), tot_c);
        check({tag, "/circ_seg"},   32'(c_seg), seg_c);
        check({tag, "/circ_wrap"},  32'(c_wrap), wrap_c);
    endtask

    initial begin
        enable = 1'b0; evt = 1'b0; clear = 1'b0; reset = 1'b1;
        rd_idx = '0; rd_idx5 = '0;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_state("reset", 0, 0, 0, 0, 0, 0);
        check("reset/sat", 32'(s_sat), 0);
        check("reset/rd", 32'(s_rd), 0);
        check("reset/stop_wrap", 32'(s_wrap), 0);

        // Basic segmentation: events on the 3rd and 5th enabled cycles.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        rd_idx = 2'd1; rd_idx5 = 3'd1;
        rq.push_back('{"pre_edge_read", 1, 1, 1});
        step(1'b1, 1'b1);
        chk_state("basic", 5, 2, 0, 5, 2, 0);
        rd(0, 0, 3, 3, 3, "basic_c0");
        rd(1, 1, 2, 2, 2, "basic_c1");
        rd(2, 7, 0, 0, 0, "read_oob");

        // Segment saturation: 20 cycles with no event.
        step(1'b0, 1'b0, 1'b1);
        check("clear/total", 32'(s_tot), 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        check("satur/total", 32'(s_tot), 20);
        check("satur/sat_stop", 32'(s_sat), 1);
        check("satur/sat_circ", 32'(c_sat), 1);
        check("satur/seg", 32'(s_seg), 0);
        rd(0, 0, 15, 15, 15, "satur_c0");

        // Fill / wrap: 5 back-to-back events, 2 quiet cycles, then one more event.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        chk_state("fill", 4, 3, 1, 5, 1, 1);
        check("fill/circ_full", 32'(c_full), 0);
        check("fill/stop_wrap", 32'(s_wrap), 0);
        check("fill/odd_full", 32'(o_full), 1);
        check("fill/odd_seg", 32'(o_seg), 4);
        check("fill/odd_total", 32'(o_tot), 5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk_state("after_full", 4, 3, 1, 8, 2, 1);
        check("after_full/sat", 32'(s_sat), 0);
        rd(0, 4, 1, 1, 1, "fill_c0");
        rd(1, 5, 1, 3, 0, "fill_c1");
        rd(2, 6, 1, 0, 0, "fill_c2");
        rd(3, 7, 1, 1, 0, "fill_c3");
        check("full_idle/stop_full", 32'(s_full), 1);

        // Disabled events never count or advance.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk_state("disabled", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0);
        chk_state("reenable", 1, 0, 0, 1, 0, 0);
        rd(0, 0, 1, 1, 1, "reenable_c0");

        // Clear together with an event wipes everything, including rd_count.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check("pre_clear/stop_full", 32'(s_full), 1);
        check("pre_clear/circ_wrap", 32'(c_wrap), 1);
        rd_idx = 2'd0; rd_idx5 = 3'd0;
        rq.push_back('{"clear_rd", 0, 0, 0});
        step(1'b1, 1'b1, 1'b1);
        chk_state("clear_evt", 0, 0, 0, 0, 0, 0);
        check("clear_evt/sat", 32'(s_sat), 0);
        rd(1, 1, 0, 0, 0, "clear_c1");
        step(1'b1, 1'b0);
        chk_state("post_clear", 1, 0, 0, 1, 0, 0);

        // Reset mid-run takes effect on that edge.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_state("mid_reset", 0, 0, 0, 0, 0, 0);

        if (rq.size() != 0) begin
            check("scoreboard_drained", 32'(rq.size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
